stream_arbiter: RTL and testbench

Packet-granular 2:1 arbiter that merges two Avalon-ST (`avln_st`) sources onto one stream feeding the line-delay buffer and downstream blocks. Sources have no backpressure, so each input has its own `Line` buffer. Grant is round-robin, held for a whole packet (sop..eop), and never interleaves packets. Sticky overflow and framing-error flags report lost or broken packets.

---
 rtl/stream_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_stream_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arbiter.sv
// Packet-granular 2:1 round-robin merge of two Avalon-ST sources, each with its own line buffer.
// Define STREAM_ARB_STATS_EN to build the per-input packet counters; otherwise they read as 0.

package avln_pkg;
    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
        logic        valid;
    } avln_st;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } avln_line_t;
endpackage

module stream_arbiter
    import avln_pkg::*;
#(
    parameter int BUF_ADDR_W = 4
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  avln_st      in0,
    input  avln_st      in1,
    output avln_st      out,
    input  logic        clr,
    output logic [1:0]  overflow,
    output logic [1:0]  frame_err,
    output logic [31:0] pkt_cnt0,
    output logic [31:0] pkt_cnt1
);

    localparam int DEPTH = 2 ** BUF_ADDR_W;
    localparam logic [BUF_ADDR_W:0]   FULL_CNT = (BUF_ADDR_W + 1)'(DEPTH);
    localparam logic [BUF_ADDR_W:0]   CNT_ONE  = (BUF_ADDR_W + 1)'(1);
    localparam logic [BUF_ADDR_W-1:0] PTR_ONE  = BUF_ADDR_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    avln_st     in_vec [2];
    avln_line_t head   [2];
    logic [1:0] nonempty;
    logic [1:0] has_two;
    logic [1:0] next_sop;
    logic [1:0] sop_head;
    logic [1:0] pop;
    logic [1:0] ovf_set;
    logic [1:0] ferr_set;

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic       rr_reg;
    logic       emit;
    logic       emit_src;
    avln_line_t emit_line;
    logic       start_a;
    logic       start_a_src;
    logic       start_b;
    logic       start_b_src;

    avln_st     out_reg;
    logic [1:0] overflow_reg;
    logic [1:0] frame_err_reg;

    assign in_vec[0] = in0;
    assign in_vec[1] = in1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            avln_line_t            mem [DEPTH];
            logic [BUF_ADDR_W-1:0] wr_ptr_reg;
            logic [BUF_ADDR_W-1:0] rd_ptr_reg;
            logic [BUF_ADDR_W:0]   count_reg;
            logic                  wr_en;

            // Room is judged on the pre-edge count: a same-edge pop never frees a slot.
            assign wr_en       = in_vec[gi].valid && (count_reg != FULL_CNT);
            assign ovf_set[gi] = in_vec[gi].valid && (count_reg == FULL_CNT);

            always_ff @(posedge sys_clk) begin
                if (wr_en) begin
                    mem[wr_ptr_reg] <= '{data:  in_vec[gi].data,
                                         sop:   in_vec[gi].sop,
                                         eop:   in_vec[gi].eop,
                                         empty: in_vec[gi].empty};
                end
            end

            always_ff @(posedge sys_clk or negedge reset_n) begin
                if (!reset_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (wr_en) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                    end
                    case ({wr_en, pop[gi]})
                        2'b10:   count_reg <= count_reg + CNT_ONE;
                        2'b01:   count_reg <= count_reg - CNT_ONE;
                        default: count_reg <= count_reg;
                    endcase
                end
            end

            assign head[gi]     = mem[rd_ptr_reg];
            assign next_sop[gi] = mem[rd_ptr_reg + PTR_ONE].sop;
            assign nonempty[gi] = (count_reg != '0);
            assign has_two[gi]  = (count_reg > CNT_ONE);
            assign sop_head[gi] = nonempty[gi] && head[gi].sop;
        end
    endgenerate

    function automatic logic [1:0] gnt_state(input logic src);
        return src ? ST_GNT1 : ST_GNT0;
    endfunction

    always_comb begin
        pop         = '0;
        ferr_set    = '0;
        emit        = 1'b0;
        emit_src    = 1'b0;
        start_a     = 1'b0;
        start_a_src = 1'b0;
        start_b     = 1'b0;
        start_b_src = 1'b0;
        state_next  = state_reg;
        emit_line   = head[0];

        case (state_reg)
            ST_IDLE: begin
                for (int i = 0; i < 2; i++) begin
                    if (nonempty[i] && !head[i].sop) begin
                        pop[i]      = 1'b1;
                        ferr_set[i] = 1'b1;
                    end
                end
                // Grant and emit the sop line on the same edge to keep idle latency at one cycle.
                if (sop_head != 2'b00) begin
                    emit        = 1'b1;
                    emit_src    = (sop_head == 2'b11) ? rr_reg : sop_head[1];
                    start_a     = 1'b1;
                    start_a_src = emit_src;
                end
            end
            ST_GNT0: begin
                emit     = nonempty[0];
                emit_src = 1'b0;
            end
            ST_GNT1: begin
                emit     = nonempty[1];
                emit_src = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase

        if (emit) begin
            pop[emit_src] = 1'b1;
            emit_line     = head[emit_src];
            if (emit_line.eop) begin
                // Next grant is chosen on the eop edge so alternating packets stay gap-free.
                if (sop_head[~emit_src]) begin
                    start_b     = 1'b1;
                    start_b_src = ~emit_src;
                    state_next  = gnt_state(~emit_src);
                end else if (has_two[emit_src] && next_sop[emit_src]) begin
                    start_b     = 1'b1;
                    start_b_src = emit_src;
                    state_next  = gnt_state(emit_src);
                end else begin
                    state_next  = ST_IDLE;
                end
            end else begin
                state_next = gnt_state(emit_src);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            rr_reg        <= 1'b0;
            out_reg       <= '0;
            overflow_reg  <= '0;
            frame_err_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (start_b) begin
                rr_reg <= ~start_b_src;
            end else if (start_a) begin
                rr_reg <= ~start_a_src;
            end
            if (emit) begin
                out_reg <= '{data:  emit_line.data,
                             sop:   emit_line.sop,
                             eop:   emit_line.eop,
                             empty: emit_line.empty,
                             valid: 1'b1};
            end else begin
                out_reg <= '0;
            end
            // A set event on the same edge as clr takes priority.
            overflow_reg  <= (overflow_reg  & ~{2{clr}}) | ovf_set;
            frame_err_reg <= (frame_err_reg & ~{2{clr}}) | ferr_set;
        end
    end

    assign out       = out_reg;
    assign overflow  = overflow_reg;
    assign frame_err = frame_err_reg;

`ifdef STREAM_ARB_STATS_EN
    logic [31:0] pkt_cnt_vec [2];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_stats
            logic [31:0] cnt_reg;
            logic [31:0] inc;

            // A one-line packet from IDLE can start two packets on one edge.
            assign inc = 32'(start_a && (start_a_src == 1'(gi)))
                       + 32'(start_b && (start_b_src == 1'(gi)));

            always_ff @(posedge sys_clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + inc;
                end
            end

            assign pkt_cnt_vec[gi] = cnt_reg;
        end
    endgenerate

    assign pkt_cnt0 = pkt_cnt_vec[0];
    assign pkt_cnt1 = pkt_cnt_vec[1];
`else
    assign pkt_cnt0 = '0;
    assign pkt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_stream_arbiter.sv
// Scoreboard bench for stream_arbiter: expected lines queued at drive time, popped as out.valid appears.

module tb_stream_arbiter;
    import avln_pkg::*;

`ifdef STREAM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clr     = 1'b0;
    avln_st      in0     = '0;
    avln_st      in1     = '0;
    avln_st      out_s;
    logic [1:0]  overflow;
    logic [1:0]  frame_err;
    logic [31:0] pkt_cnt0;
    logic [31:0] pkt_cnt1;

    int     vectors     = 0;
    int     miscompares = 0;
    avln_st exp_q[$];
    avln_st mon_exp;
    int     cur_run   = 0;
    int     last_run  = 0;
    int     exp_cnt0  = 0;
    int     exp_cnt1  = 0;

    always #5 sys_clk = ~sys_clk;

    stream_arbiter #(.BUF_ADDR_W(4)) dut (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .in0       (in0),
        .in1       (in1),
        .out       (out_s),
        .clr       (clr),
        .overflow  (overflow),
        .frame_err (frame_err),
        .pkt_cnt0  (pkt_cnt0),
        .pkt_cnt1  (pkt_cnt1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic avln_st mk(input logic [31:0] d, input logic s, input logic e);
        return '{data: d, sop: s, eop: e, empty: (e ? 2'd1 : 2'd0), valid: 1'b1};
    endfunction

    always @(negedge sys_clk) begin
        if (out_s.valid) begin
            cur_run++;
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("out line data=%h sop=%b eop=%b empty=%0d", out_s.data, out_s.sop,
                         out_s.eop, out_s.empty);
                check_eq("out_line", 64'(out_s), 64'(mon_exp));
            end
        end else begin
            if (cur_run != 0) begin
                last_run = cur_run;
                cur_run  = 0;
            end
            check_eq("out_idle_zero", 64'(out_s), 64'd0);
        end
    end

    task automatic check_cnts(input string tag);
        check_eq({tag, "_cnt0"}, 64'(pkt_cnt0), STATS ? 64'(exp_cnt0) : 64'd0);
        check_eq({tag, "_cnt1"}, 64'(pkt_cnt1), STATS ? 64'(exp_cnt1) : 64'd0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge sys_clk);
            n++;
        end
        if (exp_q.size() != 0) check_eq(tag, 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        in0 = '0;
        in1 = '0;
        #2 reset_n = 1'b0;
        exp_q.delete();
        cur_run  = 0;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        repeat (2) @(negedge sys_clk);
        #2 reset_n = 1'b1;
        @(negedge sys_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge sys_clk);
        #2 reset_n = 1'b1;
        @(negedge sys_clk);

        // Reset state
        check_eq("rst_out", 64'(out_s), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        check_eq("rst_ferr", 64'(frame_err), 64'd0);
        check_cnts("rst");

        // Single 4-line packet on in0, latency check
        for (int k = 0; k < 4; k++) begin
            in0 = mk(32'h11 + 32'(k), k == 0, k == 3);
            exp_q.push_back(in0);
            @(negedge sys_clk);
            if (k == 0) check_eq("lat_e0", 64'(out_s.valid), 64'd0);
            if (k == 1) check_eq("lat_e1", 64'(out_s.valid), 64'd1);
        end
        in0 = '0;
        drain("t1_drain");
        exp_cnt0 = 1;
        check_cnts("t1");
        check_eq("t1_run", 64'(last_run), 64'd4);

        // Simultaneous packets after reset, twice
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 3; k++) exp_q.push_back(mk(32'hA0 + 32'(k), k == 0, k == 2));
            for (int k = 0; k < 3; k++) exp_q.push_back(mk(32'hB0 + 32'(k), k == 0, k == 2));
            for (int k = 0; k < 3; k++) begin
                in0 = mk(32'hA0 + 32'(k), k == 0, k == 2);
                in1 = mk(32'hB0 + 32'(k), k == 0, k == 2);
                @(negedge sys_clk);
            end
            in0 = '0;
            in1 = '0;
            drain("t2_drain");
            exp_cnt0++;
            exp_cnt1++;
            check_eq("t2_b2b_run", 64'(last_run), 64'd6);
            check_cnts("t2");
        end

        // Continuous traffic at half rate on both inputs: grants alternate 0,1,0,1
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(mk(32'h100 + 32'(p * 4 + k), k == 0, k == 3));
            for (int k = 0; k < 4; k++) exp_q.push_back(mk(32'h200 + 32'(p * 4 + k), k == 0, k == 3));
        end
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 4; k++) begin
                in0 = mk(32'h100 + 32'(p * 4 + k), k == 0, k == 3);
                in1 = mk(32'h200 + 32'(p * 4 + k), k == 0, k == 3);
                @(negedge sys_clk);
                in0 = '0;
                in1 = '0;
                @(negedge sys_clk);
            end
        end
        drain("t3_drain");
        check_eq("t3_ovf", 64'(overflow), 64'd0);
        exp_cnt0 += 4;
        exp_cnt1 += 4;
        check_cnts("t3");

        // in1 overflows while in0's 30-line packet holds the grant
        for (int k = 0; k < 30; k++) exp_q.push_back(mk(32'h300 + 32'(k), k == 0, k == 29));
        for (int k = 0; k < 16; k++) exp_q.push_back(mk(32'h400 + 32'(k), k == 0, 1'b0));
        for (int c = 0; c < 30; c++) begin
            in0 = mk(32'h300 + 32'(c), c == 0, c == 29);
            in1 = (c >= 2 && c < 22) ? mk(32'h400 + 32'(c - 2), c == 2, c == 21) : '0;
            @(negedge sys_clk);
            if (c == 17) check_eq("ovf_16th", 64'(overflow), 64'd0);
            if (c == 18) check_eq("ovf_17th", 64'(overflow), 64'b10);
        end
        in0 = '0;
        in1 = '0;
        drain("t4_drain");
        check_eq("ovf_sticky", 64'(overflow), 64'b10);
        exp_cnt0++;
        exp_cnt1++;
        check_cnts("t4");
        clr = 1'b1;
        @(negedge sys_clk);
        clr = 1'b0;
        check_eq("ovf_clr", 64'(overflow), 64'd0);
        check_eq("t4_ferr", 64'(frame_err), 64'd0);

        // Head line without sop while idle is dropped
        do_reset();
        in0 = mk(32'hBAD, 1'b0, 1'b1);
        @(negedge sys_clk);
        in0 = '0;
        check_eq("ferr_pre", 64'(frame_err), 64'd0);
        @(negedge sys_clk);
        check_eq("ferr_set", 64'(frame_err), 64'b01);
        repeat (3) @(negedge sys_clk);
        check_cnts("t5");

        // Asynchronous reset mid-packet, then a fresh packet
        exp_q.push_back(mk(32'h31, 1'b1, 1'b0));
        exp_q.push_back(mk(32'h32, 1'b0, 1'b0));
        in0 = mk(32'h31, 1'b1, 1'b0);
        @(negedge sys_clk);
        in0 = mk(32'h32, 1'b0, 1'b0);
        @(negedge sys_clk);
        in0 = '0;
        @(negedge sys_clk);
        check_eq("pre_rst_valid", 64'(out_s.valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_valid", 64'(out_s.valid), 64'd0);
        check_eq("arst_ferr", 64'(frame_err), 64'd0);
        check_eq("arst_ovf", 64'(overflow), 64'd0);
        check_eq("arst_cnt0", 64'(pkt_cnt0), 64'd0);
        check_eq("arst_sb", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        #1 reset_n = 1'b1;
        @(negedge sys_clk);
        exp_q.push_back(mk(32'h41, 1'b1, 1'b0));
        exp_q.push_back(mk(32'h42, 1'b0, 1'b1));
        in0 = mk(32'h41, 1'b1, 1'b0);
        @(negedge sys_clk);
        check_eq("t6_lat_e0", 64'(out_s.valid), 64'd0);
        in0 = mk(32'h42, 1'b0, 1'b1);
        @(negedge sys_clk);
        check_eq("t6_lat_e1", 64'(out_s.valid), 64'd1);
        in0 = '0;
        drain("t6_drain");
        exp_cnt0 = 1;
        exp_cnt1 = 0;
        check_cnts("t6");
        check_eq("t6_ferr", 64'(frame_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
